// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the instruction-fetch port and the data port, one transaction at a time.
// Data wins by default, with a starvation guard for fetches and a watchdog that aborts stuck bus cycles.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_ram_ce_i,
  input  logic [31:0] pc_ram_addr_i,
  output logic [31:0] pc_ram_data_o,
  output logic        pc_ram_ready_o,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        ram_ready_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ready_i,
  output logic        bus_err_o,
  output logic [1:0]  grant_o
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  starve_q;
  logic [7:0]  tmo_q;
  logic        owner_data_q;
  logic        take_data;
  logic        owner_ce;
  logic [31:0] rdata;

  assign take_data = ram_ce_i && (!pc_ram_ce_i || (starve_q < STARVE_MAX));
  assign owner_ce  = owner_data_q ? ram_ce_i : pc_ram_ce_i;
  // Writes and aborted cycles return zero rather than whatever the bus drives.
  assign rdata     = (bus_ready_i && !bus_we_o) ? bus_data_i : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      starve_q       <= 4'd0;
      tmo_q          <= 8'd0;
      owner_data_q   <= 1'b0;
      pc_ram_data_o  <= 32'h0;
      pc_ram_ready_o <= 1'b0;
      ram_data_o     <= 32'h0;
      ram_ready_o    <= 1'b0;
      bus_ce_o       <= 1'b0;
      bus_we_o       <= 1'b0;
      bus_sel_o      <= 4'h0;
      bus_addr_o     <= 32'h0;
      bus_data_o     <= 32'h0;
      bus_err_o      <= 1'b0;
      grant_o        <= 2'b00;
    end else begin
      pc_ram_ready_o <= 1'b0;
      ram_ready_o    <= 1'b0;
      bus_err_o      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (take_data) begin
            state_q      <= S_BUSY;
            owner_data_q <= 1'b1;
            grant_o      <= 2'b10;
            bus_ce_o     <= 1'b1;
            bus_we_o     <= ram_we_i;
            bus_sel_o    <= ram_sel_i;
            bus_addr_o   <= ram_addr_i;
            bus_data_o   <= ram_data_i;
            tmo_q        <= 8'd0;
            starve_q     <= pc_ram_ce_i ? starve_q + 4'd1 : 4'd0;
          end else if (pc_ram_ce_i) begin
            state_q      <= S_BUSY;
            owner_data_q <= 1'b0;
            grant_o      <= 2'b01;
            bus_ce_o     <= 1'b1;
            bus_we_o     <= 1'b0;
            bus_sel_o    <= 4'hF;
            bus_addr_o   <= pc_ram_addr_i;
            bus_data_o   <= 32'h0;
            tmo_q        <= 8'd0;
            starve_q     <= 4'd0;
          end
        end
        S_BUSY: begin
          if (bus_ready_i || (tmo_q == TMO_LAST)) begin
            state_q   <= S_RESP;
            bus_ce_o  <= 1'b0;
            bus_err_o <= !bus_ready_i;
            // A requester that withdrew its request (flush) gets no completion pulse.
            if (owner_ce) begin
              if (owner_data_q) begin
                ram_ready_o <= 1'b1;
                ram_data_o  <= rdata;
              end else begin
                pc_ram_ready_o <= 1'b1;
                pc_ram_data_o  <= rdata;
              end
            end
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          grant_o <= 2'b00;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench: transaction-level requesters, a memory-backed bus slave and a scoreboard monitor.
module tb_mem_bus_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_ram_ce_i = 1'b0;
  logic [31:0] pc_ram_addr_i = 32'h0;
  logic [31:0] pc_ram_data_o;
  logic        pc_ram_ready_o;
  logic        ram_ce_i = 1'b0;
  logic        ram_we_i = 1'b0;
  logic [3:0]  ram_sel_i = 4'h0;
  logic [31:0] ram_addr_i = 32'h0;
  logic [31:0] ram_data_i = 32'h0;
  logic [31:0] ram_data_o;
  logic        ram_ready_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ready_i;
  logic        bus_err_o;
  logic [1:0]  grant_o;

  mem_bus_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .pc_ram_ce_i(pc_ram_ce_i), .pc_ram_addr_i(pc_ram_addr_i),
    .pc_ram_data_o(pc_ram_data_o), .pc_ram_ready_o(pc_ram_ready_o),
    .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
    .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i),
    .ram_data_o(ram_data_o), .ram_ready_o(ram_ready_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ready_i(bus_ready_i),
    .bus_err_o(bus_err_o), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic err; } resp_t;

  int          tests = 0;
  int          fails = 0;
  resp_t       inst_q[$];
  resp_t       data_q[$];
  resp_t       m_r;
  logic [31:0] mdl_mem [16];
  logic [31:0] slv_mem [16];
  bit          hang = 1'b0;
  int          w_lo = 0;
  int          w_hi = 3;
  int          s_cnt = 0;
  int          s_wait = 0;
  logic [3:0]  s_idx;
  logic [31:0] cur_i_addr = 32'h0;
  logic        cur_d_we = 1'b0;
  logic [3:0]  cur_d_sel = 4'h0;
  logic [31:0] cur_d_addr = 32'h0;
  logic [31:0] cur_d_wd = 32'h0;
  bit          e_pc, e_ram, e_rst;
  bit          prev_ce = 1'b0;
  int          starve = 0;
  int          busy_len = 0;
  bit          m_own_d = 1'b0;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wd;
  bit          log_en = 1'b0;
  int          gcnt = 0;
  logic [9:0]  glog = 10'h0;
  int          pc_ready_cnt = 0;
  int          mn, base;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h2402_0015;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic inst_req(input logic [31:0] a);
    int n;
    cur_i_addr = a;
    inst_q.push_back('{rom(a), 1'b0});
    pc_ram_addr_i = a;
    pc_ram_ce_i = 1'b1;
    @(negedge clk);
    n = 1;
    while (!pc_ram_ready_o && n < 200) begin @(negedge clk); n++; end
    chk("inst_req_done", 32'(pc_ram_ready_o), 32'd1);
    pc_ram_ce_i = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [3:0] sel, input logic [3:0] idx,
                          input logic [31:0] wd, input logic exp_err);
    int n;
    resp_t r;
    r.err  = exp_err;
    r.data = (we || exp_err) ? 32'h0 : mdl_mem[idx];
    if (we) for (int b = 0; b < 4; b++) if (sel[b]) mdl_mem[idx][8*b +: 8] = wd[8*b +: 8];
    cur_d_we = we; cur_d_sel = sel; cur_d_wd = wd;
    cur_d_addr = 32'h8000_0000 | {26'h0, idx, 2'b00};
    data_q.push_back(r);
    ram_we_i = we; ram_sel_i = sel; ram_addr_i = cur_d_addr; ram_data_i = wd;
    ram_ce_i = 1'b1;
    @(negedge clk);
    n = 1;
    while (!ram_ready_o && n < 200) begin @(negedge clk); n++; end
    chk("data_req_done", 32'(ram_ready_o), 32'd1);
    ram_ce_i = 1'b0;
  endtask

  always @(posedge clk) begin
    e_pc  = pc_ram_ce_i;
    e_ram = ram_ce_i;
    e_rst = rst;
  end

  // Bus slave: word memory for the data region, fixed pattern ROM for fetches.
  initial begin
    bus_ready_i = 1'b0;
    bus_data_i  = 32'h0;
    forever begin
      @(negedge clk);
      bus_ready_i = 1'b0;
      bus_data_i  = 32'h0;
      if (!bus_ce_o) s_cnt = 0;
      else if (!hang) begin
        if (s_cnt == 0) s_wait = $urandom_range(w_hi, w_lo);
        if (s_cnt == s_wait) begin
          bus_ready_i = 1'b1;
          if (!bus_addr_o[31]) bus_data_i = rom(bus_addr_o);
          else begin
            s_idx = bus_addr_o[5:2];
            if (bus_we_o) begin
              bus_data_i = $urandom();
              for (int b = 0; b < 4; b++)
                if (bus_sel_o[b]) slv_mem[s_idx][8*b +: 8] = bus_data_o[8*b +: 8];
            end else bus_data_i = slv_mem[s_idx];
          end
        end
        s_cnt++;
      end
    end
  end

  // Monitor: predicts each grant from the request lines at the decision edge and scores responses.
  always @(negedge clk) begin
    if (e_rst) begin
      prev_ce = 1'b0; starve = 0; busy_len = 0;
    end else begin
      if (bus_ce_o) begin
        if (!prev_ce) begin
          chk("grant_has_req", 32'(e_pc | e_ram), 32'd1);
          m_own_d = e_ram && (!e_pc || starve < SL);
          chk("grant_owner", 32'(grant_o), m_own_d ? 32'd2 : 32'd1);
          if (m_own_d) begin
            m_we = cur_d_we; m_sel = cur_d_sel; m_addr = cur_d_addr; m_wd = cur_d_wd;
            starve = e_pc ? starve + 1 : 0;
          end else begin
            m_we = 1'b0; m_sel = 4'h0; m_addr = cur_i_addr; m_wd = 32'h0;
            starve = 0;
          end
          if (log_en && gcnt < 10) begin glog = {glog[8:0], grant_o[1]}; gcnt++; end
          busy_len = 0;
        end
        busy_len++;
        chk("bus_addr", bus_addr_o, m_addr);
        chk("bus_we", 32'(bus_we_o), 32'(m_we));
        if (m_own_d) begin
          chk("bus_sel", 32'(bus_sel_o), 32'(m_sel));
          chk("bus_wdata", bus_data_o, m_wd);
        end
      end
      prev_ce = bus_ce_o;
      chk("ready_exclusive", 32'(pc_ram_ready_o & ram_ready_o), 32'd0);
      if (pc_ram_ready_o) begin
        pc_ready_cnt++;
        chk("pc_ready_expected", 32'(inst_q.size() > 0), 32'd1);
        if (inst_q.size() > 0) begin
          m_r = inst_q.pop_front();
          chk("pc_data", pc_ram_data_o, m_r.data);
          chk("pc_err", 32'(bus_err_o), 32'(m_r.err));
          chk("pc_grant", 32'(grant_o), 32'd1);
        end
      end
      if (ram_ready_o) begin
        chk("ram_ready_expected", 32'(data_q.size() > 0), 32'd1);
        if (data_q.size() > 0) begin
          m_r = data_q.pop_front();
          chk("ram_data", ram_data_o, m_r.data);
          chk("ram_err", 32'(bus_err_o), 32'(m_r.err));
          chk("ram_grant", 32'(grant_o), 32'd2);
          if (m_r.err) chk("timeout_len", 32'(busy_len), 32'(TO));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin mdl_mem[i] = 32'h0; slv_mem[i] = 32'h0; end
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({bus_ce_o, bus_we_o, bus_sel_o, bus_err_o, grant_o, pc_ram_ready_o, ram_ready_o}), 32'd0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_wdata", bus_data_o, 32'h0);
    chk("rst_pc_data", pc_ram_data_o, 32'h0);
    chk("rst_ram_data", ram_data_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch at minimum latency.
    w_lo = 0; w_hi = 0;
    cur_i_addr = 32'h10;
    inst_q.push_back('{32'h2402_0005, 1'b0});
    pc_ram_addr_i = 32'h10; pc_ram_ce_i = 1'b1;
    @(negedge clk);
    chk("lat_bus_ce_c1", 32'(bus_ce_o), 32'd1);
    chk("lat_ready_c1", 32'(pc_ram_ready_o), 32'd0);
    @(negedge clk);
    chk("lat_ready_c2", 32'(pc_ram_ready_o), 32'd1);
    chk("lat_data_c2", pc_ram_data_o, 32'h2402_0005);
    chk("lat_grant_c2", 32'(grant_o), 32'd1);
    pc_ram_ce_i = 1'b0;
    @(negedge clk);
    chk("lat_grant_c3", 32'(grant_o), 32'd0);
    chk("lat_ready_c3", 32'(pc_ram_ready_o), 32'd0);

    // Byte-enabled write through a 3-cycle wait, then read back.
    w_lo = 3; w_hi = 3;
    data_req(1'b1, 4'b0011, 4'd1, 32'hDEAD_BEEF, 1'b0);
    data_req(1'b0, 4'hF, 4'd1, 32'h0, 1'b0);

    // Contention with back-to-back requests on both ports.
    @(negedge clk);
    w_lo = 0; w_hi = 0; log_en = 1'b1;
    fork
      for (int k = 0; k < 9; k++) data_req(k[0], 4'hF, 4'(k + 4), $urandom(), 1'b0);
      for (int k = 0; k < 3; k++) inst_req(32'h100 + 32'(k * 4));
    join
    log_en = 1'b0;
    chk("starve_order", 32'(glog), 32'(10'b1111011110));

    // Random traffic.
    w_lo = 0; w_hi = 3;
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        inst_req($urandom() & 32'h7FFF_FFFC);
      end
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(2, 0)) @(negedge clk);
        data_req(1'($urandom_range(1, 0)), 4'($urandom_range(15, 1)), 4'($urandom_range(15, 0)),
                 $urandom(), 1'b0);
      end
    join

    // Watchdog abort on a stuck bus.
    @(negedge clk);
    hang = 1'b1;
    data_req(1'b0, 4'hF, 4'd2, 32'h0, 1'b1);
    hang = 1'b0;
    @(negedge clk);
    chk("tmo_idle_grant", 32'(grant_o), 32'd0);
    chk("tmo_bus_ce", 32'(bus_ce_o), 32'd0);

    // Fetch flushed mid-access while a data request waits.
    w_lo = 3; w_hi = 3;
    cur_i_addr = 32'h40; pc_ram_addr_i = 32'h40; pc_ram_ce_i = 1'b1;
    mn = 0;
    while (!bus_ce_o && mn < 20) begin @(negedge clk); mn++; end
    chk("flush_inst_granted", 32'(grant_o), 32'd1);
    pc_ram_ce_i = 1'b0;
    base = pc_ready_cnt;
    data_req(1'b0, 4'hF, 4'd1, 32'h0, 1'b0);
    chk("flush_no_inst_ready", 32'(pc_ready_cnt - base), 32'd0);

    // Reset while the bus is busy.
    @(negedge clk);
    hang = 1'b1;
    cur_i_addr = 32'h80; pc_ram_addr_i = 32'h80; pc_ram_ce_i = 1'b1;
    mn = 0;
    while (!bus_ce_o && mn < 20) begin @(negedge clk); mn++; end
    chk("rstb_busy", 32'(bus_ce_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstb_ctl", 32'({bus_ce_o, bus_we_o, bus_sel_o, bus_err_o, grant_o, pc_ram_ready_o, ram_ready_o}), 32'd0);
    chk("rstb_addr", bus_addr_o, 32'h0);
    rst = 1'b0; pc_ram_ce_i = 1'b0; hang = 1'b0;
    base = pc_ready_cnt;
    repeat (4) @(negedge clk);
    chk("rstb_no_ready", 32'(pc_ready_cnt - base), 32'd0);
    chk("rstb_idle", 32'({bus_ce_o, grant_o}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
